// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared constants for the hardwired control unit of the single-bus CPU:
//   - 5-bit instruction opcodes
//   - control-state encoding (cu_state_e)
//   - instruction class encoding (cu_class_e) and the opcode classifier
//   - bit positions of the opcode / Ra / Rb / Rc fields inside IR
// Configuration macro: CU_MULDIV_EN
//   defined   -> mul/div are a legal class and state T6 exists
//   undefined -> mul/div classify as illegal and T6 is not part of the encoding
// -----------------------------------------------------------------------------
package cu_pkg;

   // IR field positions
   localparam int unsigned OpMsb = 31;
   localparam int unsigned OpLsb = 27;
   localparam int unsigned RaMsb = 26;
   localparam int unsigned RaLsb = 23;
   localparam int unsigned RbMsb = 22;
   localparam int unsigned RbLsb = 19;
   localparam int unsigned RcMsb = 18;
   localparam int unsigned RcLsb = 15;

   // Opcodes
   localparam logic [4:0] OpAdd  = 5'b00011;
   localparam logic [4:0] OpSub  = 5'b00100;
   localparam logic [4:0] OpShr  = 5'b00101;
   localparam logic [4:0] OpShl  = 5'b00110;
   localparam logic [4:0] OpRor  = 5'b00111;
   localparam logic [4:0] OpRol  = 5'b01000;
   localparam logic [4:0] OpAnd  = 5'b01010;
   localparam logic [4:0] OpOr   = 5'b01011;
   localparam logic [4:0] OpMul  = 5'b01111;
   localparam logic [4:0] OpDiv  = 5'b10000;
   localparam logic [4:0] OpNeg  = 5'b10001;
   localparam logic [4:0] OpNot  = 5'b10010;
   localparam logic [4:0] OpNop  = 5'b11010;
   localparam logic [4:0] OpHalt = 5'b11011;

   // Control states. Values are fixed so the encoding does not shift when T6
   // is compiled out.
   typedef enum logic [3:0] {
      StRst   = 4'd0,
      StT0    = 4'd1,
      StT1    = 4'd2,
      StT2    = 4'd3,
      StT3    = 4'd4,
      StT4    = 4'd5,
      StT5    = 4'd6,
`ifdef CU_MULDIV_EN
      StT6    = 4'd7,
`endif
      StPause = 4'd8,
      StHalt  = 4'd9
   } cu_state_e;

   // Execute-sequence classes
   typedef enum logic [2:0] {
      ClsThree   = 3'd0,
      ClsTwo     = 3'd1,
      ClsMulDiv  = 3'd2,
      ClsNop     = 3'd3,
      ClsHalt    = 3'd4,
      ClsIllegal = 3'd5
   } cu_class_e;

   // Map an opcode onto the execute sequence it follows.
   function automatic cu_class_e op_class(input logic [4:0] op);
      cu_class_e cls;
      cls = ClsIllegal;
      case (op)
         OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr: cls = ClsThree;
         OpNeg, OpNot:                                         cls = ClsTwo;
`ifdef CU_MULDIV_EN
         OpMul, OpDiv:                                         cls = ClsMulDiv;
`endif
         OpNop:                                                cls = ClsNop;
         OpHalt:                                               cls = ClsHalt;
         default:                                              cls = ClsIllegal;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/cu_reg_decode.sv
// -----------------------------------------------------------------------------
// cu_reg_decode
// 4-to-16 one-hot decoder with enable, used for the register-file load enables
// (Rin) and bus drives (Rout).
// Ports:
//   en     in  1   decoder enable; output is all-zero when low
//   sel    in  4   register index R0..R15
//   onehot out 16  one-hot select, bit n <=> Rn
// -----------------------------------------------------------------------------
module cu_reg_decode (
   input  logic        en,
   input  logic [3:0]  sel,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Hardwired Moore control unit for the single-bus CPU datapath. A state register
// walks fetch (T0..T2) and execute (T3..T6); every datapath strobe is a decode
// of that state and the instruction held in IR.
// Configuration macro: CU_MULDIV_EN enables the mul/div sequence (T5 LOin,
// T6 HIin). Without it mul/div take the illegal-opcode path and HIin, LOin and
// Zhighout are constant 0.
// Ports:
//   Clock       in  1   system clock, rising edge
//   clear       in  1   asynchronous active-low reset
//   IR          in  32  instruction register ([31:27] op, Ra, Rb, Rc fields)
//   mem_rdy     in  1   memory data valid, ends the T1 wait
//   stop        in  1   pause request, honoured only at an instruction boundary
//   Rin         out 16  one-hot register load enables
//   Rout        out 16  one-hot register bus drives
//   PCout..LOin out 1   datapath strobes
//   opcode      out 5   ALU operation select
//   run         out 1   high in T0..T6
//   illegal_op  out 1   one-cycle pulse in T3 for an undecodable opcode
// -----------------------------------------------------------------------------
module control_unit
   import cu_pkg::*;
(
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        mem_rdy,
   input  logic        stop,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic [4:0]  opcode,
   output logic        run,
   output logic        illegal_op
);

   cu_state_e  state_q;
   logic       t1_wait_q;   // set once T1 has already spent a cycle waiting on memory
   cu_state_e  end_state;   // successor of the final execute state

   logic [4:0] op;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   cu_class_e  cls;

   logic       rin_en;
   logic       rout_en;
   logic [3:0] rout_sel;

   logic       unused_ir;

   assign op  = IR[OpMsb:OpLsb];
   assign ra  = IR[RaMsb:RaLsb];
   assign rb  = IR[RbMsb:RbLsb];
   assign rc  = IR[RcMsb:RcLsb];
   assign cls = op_class(op);

   // Immediate/address bits are not needed by the sequencer.
   assign unused_ir = ^IR[RcLsb-1:0];

   // stop is only looked at when an instruction completes.
   assign end_state = stop ? StPause : StT0;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q   <= StRst;
         t1_wait_q <= 1'b0;
      end else begin
         t1_wait_q <= (state_q == StT1) && !mem_rdy;
         case (state_q)
            StRst: state_q <= StT0;
            StT0:  state_q <= StT1;
            StT1: begin
               if (mem_rdy) begin
                  state_q <= StT2;
               end
            end
            StT2:  state_q <= StT3;
            StT3: begin
               case (cls)
                  ClsThree, ClsTwo, ClsMulDiv: state_q <= StT4;
                  ClsHalt:                     state_q <= StHalt;
                  default:                     state_q <= end_state;
               endcase
            end
            StT4: begin
               if (cls == ClsThree || cls == ClsMulDiv) begin
                  state_q <= StT5;
               end else begin
                  state_q <= end_state;
               end
            end
            StT5: begin
`ifdef CU_MULDIV_EN
               if (cls == ClsMulDiv) begin
                  state_q <= StT6;
               end else begin
                  state_q <= end_state;
               end
`else
               state_q <= end_state;
`endif
            end
`ifdef CU_MULDIV_EN
            StT6:  state_q <= end_state;
`endif
            StPause: begin
               if (!stop) begin
                  state_q <= StT0;
               end
            end
            StHalt:  state_q <= StHalt;
            default: state_q <= StRst;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode (Moore: state register + IR only)
   // ---------------------------------------------------------------------------
   always_comb begin
      rin_en     = 1'b0;
      rout_en    = 1'b0;
      rout_sel   = rb;
      PCout      = 1'b0;
      PCin       = 1'b0;
      IncPC      = 1'b0;
      MARin      = 1'b0;
      Read       = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      Zin        = 1'b0;
      Zlowout    = 1'b0;
      Zhighout   = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      opcode     = 5'b00000;
      run        = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         StT0: begin
            run   = 1'b1;
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         StT1: begin
            run   = 1'b1;
            Read  = 1'b1;
            MDRin = 1'b1;
            // The incremented PC is written back only once, however long
            // memory keeps us waiting.
            if (!t1_wait_q) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
            end
         end
         StT2: begin
            run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         StT3: begin
            run = 1'b1;
            case (cls)
               ClsThree: begin
                  rout_en  = 1'b1;
                  rout_sel = rb;
                  Yin      = 1'b1;
               end
               ClsTwo: begin
                  rout_en  = 1'b1;
                  rout_sel = rb;
                  opcode   = op;
                  Zin      = 1'b1;
               end
`ifdef CU_MULDIV_EN
               ClsMulDiv: begin
                  rout_en  = 1'b1;
                  rout_sel = ra;
                  Yin      = 1'b1;
               end
`endif
               ClsIllegal: illegal_op = 1'b1;
               default: ;
            endcase
         end
         StT4: begin
            run = 1'b1;
            case (cls)
               ClsThree: begin
                  rout_en  = 1'b1;
                  rout_sel = rc;
                  opcode   = op;
                  Zin      = 1'b1;
               end
               ClsTwo: begin
                  Zlowout = 1'b1;
                  rin_en  = 1'b1;
               end
`ifdef CU_MULDIV_EN
               ClsMulDiv: begin
                  rout_en  = 1'b1;
                  rout_sel = rb;
                  opcode   = op;
                  Zin      = 1'b1;
               end
`endif
               default: ;
            endcase
         end
         StT5: begin
            run = 1'b1;
            case (cls)
               ClsThree: begin
                  Zlowout = 1'b1;
                  rin_en  = 1'b1;
               end
`ifdef CU_MULDIV_EN
               ClsMulDiv: begin
                  Zlowout = 1'b1;
                  LOin    = 1'b1;
               end
`endif
               default: ;
            endcase
         end
`ifdef CU_MULDIV_EN
         StT6: begin
            run      = 1'b1;
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Destination register is always Ra.
   cu_reg_decode u_rin_decode (
      .en     (rin_en),
      .sel    (ra),
      .onehot (Rin)
   );

   cu_reg_decode u_rout_decode (
      .en     (rout_en),
      .sel    (rout_sel),
      .onehot (Rout)
   );

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Self-checking bench for control_unit. Per-cycle expected outputs are derived
// from the instruction sequences, queued when the cycle is driven and compared
// on the falling edge. A table of instructions gives the expected T0-to-T0
// latency of each.
// -----------------------------------------------------------------------------
module tb_control_unit;

   // Strobe bit positions inside obs_t.stb
   localparam int BPcout  = 13;
   localparam int BPcin   = 12;
   localparam int BIncpc  = 11;
   localparam int BMarin  = 10;
   localparam int BRead   = 9;
   localparam int BMdrin  = 8;
   localparam int BMdrout = 7;
   localparam int BIrin   = 6;
   localparam int BYin    = 5;
   localparam int BZin    = 4;
   localparam int BZlow   = 3;
   localparam int BZhigh  = 2;
   localparam int BHiin   = 1;
   localparam int BLoin   = 0;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  opc;
      logic [13:0] stb;
      logic        run;
      logic        ill;
   } obs_t;

   typedef struct {
      obs_t  o;
      bit    rdy;
      bit    stp;
      string tag;
   } step_t;

   typedef struct {
      string       name;
      logic [31:0] ir;
      int          lows;
      bit          stop_mid;
      int          lat;
   } vec_t;

   logic        Clock;
   logic        clear;
   logic [31:0] IR;
   logic        mem_rdy;
   logic        stop;
   logic [15:0] Rin;
   logic [15:0] Rout;
   logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
   logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
   logic [4:0]  opcode;
   logic        run;
   logic        illegal_op;

   obs_t  obs;
   step_t plan[$];
   step_t sb[$];
   vec_t  vecs[11];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    t0_prev = 0;
   int    t0_gap = 0;
   string cur_name = "init";

   control_unit u_dut (
      .Clock      (Clock),
      .clear      (clear),
      .IR         (IR),
      .mem_rdy    (mem_rdy),
      .stop       (stop),
      .Rin        (Rin),
      .Rout       (Rout),
      .PCout      (PCout),
      .PCin       (PCin),
      .IncPC      (IncPC),
      .MARin      (MARin),
      .Read       (Read),
      .MDRin      (MDRin),
      .MDRout     (MDRout),
      .IRin       (IRin),
      .Yin        (Yin),
      .Zin        (Zin),
      .Zlowout    (Zlowout),
      .Zhighout   (Zhighout),
      .HIin       (HIin),
      .LOin       (LOin),
      .opcode     (opcode),
      .run        (run),
      .illegal_op (illegal_op)
   );

   assign obs = {Rin, Rout, opcode, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                 Yin, Zin, Zlowout, Zhighout, HIin, LOin, run, illegal_op};

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
               checks, errors);
      $fatal(1);
   end

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: one queued expectation per driven cycle.
   always @(negedge Clock) begin
      step_t s;
      if (clear && PCout) begin
         t0_gap  <= cyc - t0_prev;
         t0_prev <= cyc;
      end
      if (sb.size() > 0) begin
         s = sb.pop_front();
         chk(s.tag, 64'(obs), 64'(s.o));
      end
   end

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'd0};
   endfunction

   task automatic add_plan(input obs_t o, input bit rdy, input bit stp, input string tag);
      step_t s;
      s.o   = o;
      s.rdy = rdy;
      s.stp = stp;
      s.tag = tag;
      plan.push_back(s);
   endtask

   // Expected cycle-by-cycle outputs of one instruction, from T0 to its last state.
   task automatic build(input logic [31:0] ir, input int lows, input bit stop_mid,
                        input bit stop_end);
      obs_t        o;
      obs_t        ex[$];
      logic [4:0]  op;
      logic [15:0] ra1, rb1, rc1;
      plan.delete();
      op  = ir[31:27];
      ra1 = 16'h0001 << ir[26:23];
      rb1 = 16'h0001 << ir[22:19];
      rc1 = 16'h0001 << ir[18:15];

      o = '0; o.run = 1'b1;
      o.stb[BPcout] = 1'b1; o.stb[BMarin] = 1'b1; o.stb[BIncpc] = 1'b1; o.stb[BZin] = 1'b1;
      add_plan(o, 1'b1, stop_mid, "T0");
      for (int k = 0; k <= lows; k++) begin
         o = '0; o.run = 1'b1;
         o.stb[BRead] = 1'b1; o.stb[BMdrin] = 1'b1;
         if (k == 0) begin
            o.stb[BPcin] = 1'b1; o.stb[BZlow] = 1'b1;
         end
         add_plan(o, k == lows, stop_mid, $sformatf("T1.%0d", k));
      end
      o = '0; o.run = 1'b1; o.stb[BMdrout] = 1'b1; o.stb[BIrin] = 1'b1;
      add_plan(o, 1'b1, stop_mid, "T2");

      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01010, 5'b01011: begin
            o = '0; o.run = 1'b1; o.rout = rb1; o.stb[BYin] = 1'b1; ex.push_back(o);
            o = '0; o.run = 1'b1; o.rout = rc1; o.opc = op; o.stb[BZin] = 1'b1; ex.push_back(o);
            o = '0; o.run = 1'b1; o.rin = ra1; o.stb[BZlow] = 1'b1; ex.push_back(o);
         end
         5'b10001, 5'b10010: begin
            o = '0; o.run = 1'b1; o.rout = rb1; o.opc = op; o.stb[BZin] = 1'b1; ex.push_back(o);
            o = '0; o.run = 1'b1; o.rin = ra1; o.stb[BZlow] = 1'b1; ex.push_back(o);
         end
`ifdef CU_MULDIV_EN
         5'b01111, 5'b10000: begin
            o = '0; o.run = 1'b1; o.rout = ra1; o.stb[BYin] = 1'b1; ex.push_back(o);
            o = '0; o.run = 1'b1; o.rout = rb1; o.opc = op; o.stb[BZin] = 1'b1; ex.push_back(o);
            o = '0; o.run = 1'b1; o.stb[BZlow] = 1'b1; o.stb[BLoin] = 1'b1; ex.push_back(o);
            o = '0; o.run = 1'b1; o.stb[BZhigh] = 1'b1; o.stb[BHiin] = 1'b1; ex.push_back(o);
         end
`endif
         5'b11010, 5'b11011: begin
            o = '0; o.run = 1'b1; ex.push_back(o);
         end
         default: begin
            o = '0; o.run = 1'b1; o.ill = 1'b1; ex.push_back(o);
         end
      endcase
      for (int j = 0; j < ex.size(); j++) begin
         add_plan(ex[j], 1'b1, (j == ex.size() - 1) ? stop_end : stop_mid,
                  $sformatf("T%0d", 3 + j));
      end
   endtask

   // Drive the first n planned cycles; IR changes only after T0 has started.
   task automatic apply(input logic [31:0] ir, input int n, input int prev_lat);
      step_t s;
      for (int j = 0; j < n && j < plan.size(); j++) begin
         @(posedge Clock);
         #1;
         if (j == 0) IR = ir;
         mem_rdy = plan[j].rdy;
         stop    = plan[j].stp;
         s       = plan[j];
         s.tag   = {cur_name, "/", plan[j].tag};
         sb.push_back(s);
         if (j == 0 && prev_lat > 0) begin
            @(negedge Clock);
            #1;
            chk({cur_name, "/latency_prev"}, 64'(t0_gap), 64'(prev_lat));
         end
      end
   endtask

   task automatic step(input obs_t o, input bit rdy, input bit stp, input string tag);
      step_t s;
      @(posedge Clock);
      #1;
      mem_rdy = rdy;
      stop    = stp;
      s.o     = o;
      s.rdy   = rdy;
      s.stp   = stp;
      s.tag   = tag;
      sb.push_back(s);
   endtask

   initial begin
      logic [31:0] add_ir;
      add_ir = 32'h5091_8000;   // and R1,R2,R3

      vecs[0]  = '{"and_r1_r2_r3", add_ir, 0, 1'b0, 6};
      vecs[1]  = '{"and_wait3", add_ir, 3, 1'b0, 9};
      vecs[2]  = '{"sub_wait1_stopmid", mk(5'b00100, 4'd5, 4'd6, 4'd7), 1, 1'b1, 7};
      vecs[3]  = '{"neg", mk(5'b10001, 4'd9, 4'd10, 4'd0), 0, 1'b0, 5};
      vecs[4]  = '{"not_r15_wait2", mk(5'b10010, 4'd15, 4'd0, 4'd0), 2, 1'b1, 7};
`ifdef CU_MULDIV_EN
      vecs[5]  = '{"mul_r4_r5", mk(5'b01111, 4'd4, 4'd5, 4'd0), 0, 1'b0, 7};
      vecs[6]  = '{"div_r14_r13", mk(5'b10000, 4'd14, 4'd13, 4'd0), 0, 1'b0, 7};
`else
      vecs[5]  = '{"mul_r4_r5", mk(5'b01111, 4'd4, 4'd5, 4'd0), 0, 1'b0, 4};
      vecs[6]  = '{"div_r14_r13", mk(5'b10000, 4'd14, 4'd13, 4'd0), 0, 1'b0, 4};
`endif
      vecs[7]  = '{"nop", 32'hD000_0000, 0, 1'b0, 4};
      vecs[8]  = '{"illegal_11111", 32'hF800_0000, 0, 1'b0, 4};
      vecs[9]  = '{"or_r0_r15_r1", mk(5'b01011, 4'd0, 4'd15, 4'd1), 0, 1'b0, 6};
      vecs[10] = '{"nop_tail", 32'hD000_0000, 0, 1'b0, 4};

      // Reset: outputs must be zero
      clear   = 1'b1;
      IR      = 32'h0;
      mem_rdy = 1'b0;
      stop    = 1'b0;
      #3 clear = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      chk("reset/outputs", 64'(obs), 64'(0));
      @(negedge Clock);
      clear = 1'b1;

      // Table-driven instruction stream, back to back
      for (int i = 0; i < 11; i++) begin
         cur_name = vecs[i].name;
         build(vecs[i].ir, vecs[i].lows, vecs[i].stop_mid, 1'b0);
         apply(vecs[i].ir, plan.size(), (i > 0) ? vecs[i-1].lat : 0);
      end

      // stop at the end of an instruction -> PAUSE, then resume
      cur_name = "stop_pause";
      build(add_ir, 0, 1'b0, 1'b1);
      apply(add_ir, plan.size(), 0);
      step('0, 1'b1, 1'b1, "stop_pause/pause0");
      step('0, 1'b0, 1'b1, "stop_pause/pause1");
      step('0, 1'b1, 1'b0, "stop_pause/pause_release");
      cur_name = "after_pause";
      build(32'hD000_0000, 0, 1'b0, 1'b0);
      apply(32'hD000_0000, plan.size(), 0);

      // clear during T4 of and: immediate zero, no Rin later, restart at T0
      cur_name = "abort";
      build(add_ir, 0, 1'b0, 1'b0);
      apply(add_ir, 4, 0);
      @(posedge Clock);
      #1;
      chk("abort/t4_zin", 64'(Zin), 64'(1));
      #2 clear = 1'b0;
      #1 chk("abort/async_zero", 64'(obs), 64'(0));
      step('0, 1'b1, 1'b0, "abort/hold0");
      step('0, 1'b1, 1'b0, "abort/hold1");
      @(negedge Clock);
      clear = 1'b1;
      cur_name = "after_abort";
      build(add_ir, 0, 1'b0, 1'b0);
      apply(add_ir, plan.size(), 0);

      // halt: absorbing despite stop toggling, left only through clear
      cur_name = "halt";
      build(32'hD800_0000, 0, 1'b0, 1'b0);
      apply(32'hD800_0000, plan.size(), 0);
      for (int k = 0; k < 20; k++) begin
         step('0, k[1], k[0], $sformatf("halt/hold%0d", k));
      end
      @(negedge Clock);
      #1 clear = 1'b0;
      #1 chk("halt/clear_zero", 64'(obs), 64'(0));
      @(negedge Clock);
      clear = 1'b1;
      cur_name = "after_halt";
      build(add_ir, 1, 1'b0, 1'b0);
      apply(add_ir, plan.size(), 0);

      @(negedge Clock);
      #1;
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
